spi_regif: RTL and testbench
============================

Name: spi_regif

Overview:
- Serial slave front-end that gives an off-chip SPI master access to the PLL control register file.
- Deserialises 16-bit frames on mosi and drives the register file's wre/addr/din write port.
- For read frames, serialises the register file's combinational dout back on miso.
- Runs entirely in the sclk domain; the register file captures on negedge sclk, this block acts on posedge sclk.

Parameters:
- REGCOUNT, 14, number of implemented registers; addresses >= REGCOUNT are out of range.
- ADDR_W, 8, width of addr toward the register file.
- DATA_W, 8, register width. Fixed at 8; other values are unsupported.

Ports:
- sclk  in  1  SPI clock, the block's only clock. Idle low (mode 0).
- rst  in  1  asynchronous, active-high reset.
- csb  in  1  chip select, active low. High asynchronously clears frame state.
- mosi  in  1  serial data from master, MSB first.
- miso  out  1  serial read data to master.
- wre  out  1  write enable to register file.
- addr  out  ADDR_W  register address to register file.
- din  out  DATA_W  write data to register file.
- dout  in  DATA_W  combinational read data from register file for the current addr.
- busy  out  1  high while csb is low and bit_cnt < 16.

Behaviour:
- Frame format, 16 bits, MSB first, mosi sampled on posedge sclk:
  - bit 0: R/W, 1 = write.
  - bits 1-7: addr[6:0]; addr[7] is always 0.
  - bits 8-15: write data (write frame) or don't-care (read frame).
- Reset (rst high, asynchronous):
  - wre=0, addr=0, din=0, miso=0.
  - bit_cnt=0, rw_q=0, rx_sr=0, tx_sr=0.
- csb high (asynchronous, same clear path as rst for frame state only):
  - bit_cnt=0, rx_sr=0, tx_sr=0, wre_q=0.
  - addr and din hold their last values.
- bit_cnt: 5-bit, increments on each posedge with csb low, saturates at 16. Bits after the 16th are ignored (no second access).
- Posedge 1: rw_q <= mosi.
- Posedges 2-8: addr shifts in. At posedge 8, addr <= {1'b0, rx_sr[5:0], mosi}.
- Posedges 9-16: data shifts into rx_sr. At posedge 16:
  - din <= {rx_sr[6:0], mosi}.
  - wre_q <= rw_q & (addr < REGCOUNT).
- wre output = wre_q & ~csb.
  - Register file commits at the negedge following posedge 16.
  - wre_q clears at the next posedge or on csb high.
  - Exactly one write per frame.
- Out-of-range write (addr >= REGCOUNT): wre never asserts; frame otherwise completes normally.
- Read path:
  - Bit period 8, after posedge 8: miso = (addr < REGCOUNT) ? dout[7] : 0, combinational from the fresh addr.
  - Posedge 9: tx_sr <= in-range ? {dout[6:0], 1'b0} : 0.
  - Posedges 10-15: tx_sr shifts left; miso = tx_sr[7].
  - Master samples miso on negedge sclk. miso is 0 outside bit periods 8-15 and in write frames.
- Truncated frame (csb high before posedge 16): no write; partial state discarded. addr may already have been updated if posedge 8 occurred.
- rst asserted mid-frame overrides everything; the first posedge after release with csb low is bit 0.
- Latency: write committed 0.5 sclk after the last data bit. Read data available 0.5 sclk after the last address bit.

Decomposition:
- Shared package regif_pkg holds:
  - frame constants: FRAME_LEN=16, RW_BIT=0, ADDR_LAST=8, DATA_LAST=16.
  - REGCOUNT default, shared with the register file.
- Optional sub-module spi_shift8 (8-bit parallel-load / serial shift register); used once for rx and once for tx.
- Counter and control logic stay in the top module.

Test Plan:
- Write frame 1_0000010_A5 (write addr 0x02, data 0xA5) -> addr=0x02 after posedge 8; din=0xA5 and wre=1 after posedge 16; wre=0 after posedge 17 or on csb rise; register 2 reads 0xA5.
- After a 0x5C write to addr 0x0B, read frame 0_0001011_xx -> miso bits 8-15 = 0,1,0,1,1,1,0,0 (0x5C); wre stays 0 throughout.
- Write to addr 0x0E (= REGCOUNT) with 0xFF -> wre never asserts. Read of addr 0x7F -> miso all zeros.
- Write frame with csb raised after posedge 12 -> no wre pulse. Next full write to addr 0x01 with 0x3C -> exactly one wre pulse, din=0x3C.
- 20-clock frame with csb held low, write addr 0x03 data 0x11 -> exactly one wre pulse; extra bits ignored; busy=0 from posedge 16.
- rst pulse at posedge 6 of a write frame -> all outputs 0 immediately. Subsequent clean frame (write addr 0x04, data 0x77) works, with bit 0 taken at the first posedge after rst release.

Source files
------------

// File: rtl/regif_pkg.sv
// Shared constants and types for the SPI register-file front-end.
package regif_pkg;

  localparam int unsigned FRAME_LEN    = 16;
  localparam int unsigned RW_BIT       = 0;
  localparam int unsigned ADDR_LAST    = 8;
  localparam int unsigned DATA_LAST    = 16;
  localparam int unsigned REGCOUNT_DEF = 14;
  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned CNT_W        = 5;

  // Frame phase as a function of posedges already taken; PH_DATA also
  // covers the read-out bit periods 8-15.
  typedef enum logic [1:0] {
    PH_RW,
    PH_ADDR,
    PH_DATA,
    PH_DONE
  } phase_e;

  function automatic phase_e phase_of(input logic [CNT_W-1:0] cnt);
    phase_e ph;
    if (cnt == CNT_W'(RW_BIT)) begin
      ph = PH_RW;
    end else if (cnt < CNT_W'(ADDR_LAST)) begin
      ph = PH_ADDR;
    end else if (cnt < CNT_W'(DATA_LAST)) begin
      ph = PH_DATA;
    end else begin
      ph = PH_DONE;
    end
    return ph;
  endfunction

endpackage

// File: rtl/spi_regif_if.sv
// SPI pins plus register-file write/read port of the SPI front-end.
interface spi_regif_if #(
  parameter int unsigned ADDR_W = regif_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = regif_pkg::DATA_W_DEF
) ();

  logic              csb;
  logic              mosi;
  logic              miso;
  logic              wre;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  // Off-chip master together with the register file it reaches
  modport master (
    output csb, mosi, dout,
    input  miso, wre, busy, addr, din
  );

  // SPI slave front-end
  modport slave (
    input  csb, mosi, dout,
    output miso, wre, busy, addr, din
  );

endinterface

// File: rtl/spi_shift8.sv
// 8-bit shift register: async clear, parallel load, shift left with serial in.
module spi_shift8 (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] par_in,
  input  logic       ser_in,
  output logic [7:0] q
);

  // Load has priority over shift; clear wins over both
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 8'h00;
    end else if (load) begin
      q <= par_in;
    end else if (shift) begin
      q <= {q[6:0], ser_in};
    end
  end

endmodule

// File: rtl/spi_regif.sv
// SPI mode-0 slave giving an off-chip master access to the PLL register file.
module spi_regif
  import regif_pkg::*;
#(
  parameter int unsigned REGCOUNT = REGCOUNT_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input logic        sclk,
  input logic        rst,
  spi_regif_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(REGCOUNT);

  logic [CNT_W-1:0]  bit_cnt;
  phase_e            phase;
  logic              frame_clr;
  logic              done;
  logic              addr_edge;
  logic              data_edge;
  logic              tx_load;
  logic              tx_shift;
  logic              in_range;
  logic              rw_q;
  logic              wre_q;
  logic              miso_c;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] tx_par;
  logic              unused_sr;

  // Frame state is dropped by reset or by chip select going high
  assign frame_clr = rst | bus.csb;
  assign phase     = phase_of(bit_cnt);
  assign done      = (phase == PH_DONE);
  assign addr_edge = (bit_cnt == CNT_W'(ADDR_LAST - 1));
  assign data_edge = (bit_cnt == CNT_W'(DATA_LAST - 1));
  assign tx_load   = (bit_cnt == CNT_W'(ADDR_LAST));
  assign tx_shift  = (phase == PH_DATA) && !tx_load;
  assign in_range  = (addr_q < ADDR_LIMIT);
  assign tx_par    = in_range ? {bus.dout[DATA_W-2:0], 1'b0} : '0;

  // Posedge counter, saturating so trailing bits never start a second access
  always_ff @(posedge sclk or posedge frame_clr) begin
    if (frame_clr) begin
      bit_cnt <= '0;
    end else if (!done) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Header and write-port registers; addr/din survive chip-select deassertion
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      rw_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (!bus.csb) begin
      if (phase == PH_RW) begin
        rw_q <= bus.mosi;
      end
      if (addr_edge) begin
        addr_q <= ADDR_W'({rx_q[5:0], bus.mosi});
      end
      if (data_edge) begin
        din_q <= DATA_W'({rx_q[DATA_W-2:0], bus.mosi});
      end
    end
  end

  // One-cycle write strobe raised by the last data bit of an in-range write
  always_ff @(posedge sclk or posedge frame_clr) begin
    if (frame_clr) begin
      wre_q <= 1'b0;
    end else begin
      wre_q <= data_edge & rw_q & in_range;
    end
  end

  spi_shift8 u_rx (
    .clk    (sclk),
    .clr    (frame_clr),
    .load   (1'b0),
    .shift  (!done),
    .par_in (8'h00),
    .ser_in (bus.mosi),
    .q      (rx_q)
  );

  spi_shift8 u_tx (
    .clk    (sclk),
    .clr    (frame_clr),
    .load   (tx_load),
    .shift  (tx_shift),
    .par_in (tx_par),
    .ser_in (1'b0),
    .q      (tx_q)
  );

  // Read data: MSB straight from dout in period 8, then from the tx register
  always_comb begin
    miso_c = 1'b0;
    if (!rw_q && (phase == PH_DATA)) begin
      miso_c = tx_load ? (in_range & bus.dout[DATA_W-1]) : tx_q[DATA_W-1];
    end
  end

  assign bus.miso  = miso_c;
  assign bus.wre   = wre_q & ~bus.csb;
  assign bus.busy  = ~bus.csb & ~done;
  assign bus.addr  = addr_q;
  assign bus.din   = din_q;
  assign unused_sr = ^{rx_q[DATA_W-1], tx_q[DATA_W-2:0]};

endmodule

// File: tb/tb_spi_regif.sv
// Bench for spi_regif: directed scenarios plus random frames against a register-file model.
module tb_spi_regif;

  localparam int REGS = 14;

  logic sclk;
  logic rst;

  spi_regif_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  spi_regif #(.REGCOUNT(14), .ADDR_W(8), .DATA_W(8)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  regs    [0:15];
  logic [7:0]  exp_mem [0:15];
  int          wre_rises = 0;

  logic        o_wre  [0:31];
  logic        o_busy [0:31];
  logic [7:0]  o_addr [0:31];
  logic [7:0]  o_din  [0:31];
  logic [15:0] miso_vec;
  logic        post_wre;
  int          pulses;

  // Register file: combinational read, commit on negedge while wre is high
  assign bus.dout = (bus.addr < 8'(REGS)) ? regs[bus.addr[3:0]] : 8'hFF;

  always @(negedge sclk) begin
    if (bus.wre === 1'b1 && bus.addr < 8'(REGS)) regs[bus.addr[3:0]] = bus.din;
  end

  always @(posedge bus.wre) wre_rises = wre_rises + 1;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic rw, input logic [6:0] a, input logic [7:0] d);
    return {rw, a, d};
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    if (a < REGS) return exp_mem[a];
    return 8'h00;
  endfunction

  // Drive one frame of nclk bits (bits past 16 are random); record per-posedge outputs
  task automatic frame(input logic [15:0] f, input int nclk, input bit hold_csb);
    int w0;
    w0 = wre_rises;
    miso_vec = 16'h0000;
    post_wre = 1'b0;
    bus.csb = 1'b0;
    for (int k = 1; k <= nclk; k++) begin
      bus.mosi = (k <= 16) ? f[16-k] : 1'($urandom);
      #5 sclk = 1'b1;
      #2;
      o_wre[k]  = bus.wre;
      o_busy[k] = bus.busy;
      o_addr[k] = bus.addr;
      o_din[k]  = bus.din;
      if (k <= 16) miso_vec[16-k] = bus.miso;
      #3 sclk = 1'b0;
    end
    #2;
    if (!hold_csb) begin
      bus.csb = 1'b1;
      #1 post_wre = bus.wre;
      #4;
    end
    pulses = wre_rises - w0;
  endtask

  task automatic do_read(input int a, input string tag);
    frame(mk(1'b0, 7'(a), 8'($urandom)), 16, 1'b0);
    chk({tag, "_miso"}, 32'(miso_vec), 32'({7'b0, ref_rd(a), 1'b0}));
    chk({tag, "_nowre"}, 32'(pulses), 32'd0);
  endtask

  task automatic do_write(input int a, input logic [7:0] d, input string tag);
    frame(mk(1'b1, 7'(a), d), 16, 1'b0);
    chk({tag, "_addr"}, 32'(o_addr[8]), 32'(a));
    chk({tag, "_din"}, 32'(o_din[16]), 32'(d));
    chk({tag, "_pulses"}, 32'(pulses), (a < REGS) ? 32'd1 : 32'd0);
    chk({tag, "_miso"}, 32'(miso_vec), 32'd0);
    if (a < REGS) exp_mem[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    sclk = 1'b0;
    rst = 1'b1;
    bus.csb = 1'b1;
    bus.mosi = 1'b0;
    #12;
    chk("rst_wre", 32'(bus.wre), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_din", 32'(bus.din), 32'd0);
    chk("rst_miso", 32'(bus.miso), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    #5;

    // Write 0xA5 to 0x02 with one trailing clock
    frame(mk(1'b1, 7'h02, 8'hA5), 17, 1'b0);
    chk("w1_addr8", 32'(o_addr[8]), 32'h02);
    chk("w1_wre15", 32'(o_wre[15]), 32'd0);
    chk("w1_wre16", 32'(o_wre[16]), 32'd1);
    chk("w1_din16", 32'(o_din[16]), 32'hA5);
    chk("w1_wre17", 32'(o_wre[17]), 32'd0);
    chk("w1_pulses", 32'(pulses), 32'd1);
    chk("w1_reg2", 32'(regs[2]), 32'hA5);
    exp_mem[2] = 8'hA5;

    // Write then read back 0x5C at 0x0B
    do_write(11, 8'h5C, "w2");
    chk("w2_postcsb", 32'(post_wre), 32'd0);
    do_read(11, "r2");
    do_read(2, "r2b");

    // Out-of-range write and read
    do_write(14, 8'hFF, "w3_oor");
    do_read(127, "r3_oor");
    chk("r3_addr", 32'(o_addr[8]), 32'h7F);
    do_read(14, "r3_oor14");

    // Truncated write, then a clean one
    frame(mk(1'b1, 7'h01, 8'hC3), 12, 1'b0);
    chk("t4_trunc_pulses", 32'(pulses), 32'd0);
    chk("t4_trunc_reg1", 32'(regs[1]), 32'h00);
    do_write(1, 8'h3C, "t4_full");
    do_read(1, "t4_rd");

    // Long frame: extra bits must not cause a second access
    frame(mk(1'b1, 7'h03, 8'h11), 20, 1'b0);
    chk("t5_pulses", 32'(pulses), 32'd1);
    chk("t5_din", 32'(o_din[20]), 32'h11);
    chk("t5_busy15", 32'(o_busy[15]), 32'd1);
    chk("t5_busy16", 32'(o_busy[16]), 32'd0);
    chk("t5_busy20", 32'(o_busy[20]), 32'd0);
    chk("t5_wre17", 32'(o_wre[17]), 32'd0);
    exp_mem[3] = 8'h11;

    // Reset in the middle of a write frame
    frame(mk(1'b1, 7'h05, 8'h99), 6, 1'b1);
    rst = 1'b1;
    #2;
    chk("t6_wre", 32'(bus.wre), 32'd0);
    chk("t6_addr", 32'(bus.addr), 32'd0);
    chk("t6_din", 32'(bus.din), 32'd0);
    chk("t6_miso", 32'(bus.miso), 32'd0);
    #3 rst = 1'b0;
    #3;
    do_write(4, 8'h77, "t6_clean");
    chk("t6_reg4", 32'(regs[4]), 32'h77);
    chk("t6_reg5", 32'(regs[5]), 32'h00);

    // Random frames against the reference memory
    for (int n = 0; n < 30; n++) begin
      int a;
      logic [7:0] d;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 127)) : int'($urandom_range(0, 13));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, d, "rnd_w");
      else do_read(a, "rnd_r");
    end
    for (int i = 0; i < REGS; i++) chk("final_reg", 32'(regs[i]), 32'(exp_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
